// File: rtl/jet_sprite_renderer_if.sv
// Sprite ROM and palette bus between jet_sprite_renderer (master) and the
// sprite ROMs / colour mapper (slave).
interface jet_sprite_renderer_if #(
   parameter int NUM_SPR = 2,
   parameter int ADDR_W  = 13
);
   logic [NUM_SPR*ADDR_W-1:0] rom_addr;
   logic [NUM_SPR*4-1:0]      rom_q;
   logic [3:0]                pal_index;
   logic [3:0]                pal_red;
   logic [3:0]                pal_green;
   logic [3:0]                pal_blue;

   modport master (
      output rom_addr, pal_index,
      input  rom_q, pal_red, pal_green, pal_blue
   );

   modport slave (
      input  rom_addr, pal_index,
      output rom_q, pal_red, pal_green, pal_blue
   );
endinterface

// File: rtl/jet_sprite_renderer.sv
// Multi-sprite pixel pipeline: hit test/addressing, transparency + priority, palette output.
// Optional horizontal mirroring is enabled by defining JET_SPRITE_FLIP_EN.
module jet_sprite_renderer #(
   parameter int         SPR_W      = 80,
   parameter int         SPR_H      = 80,
   parameter int         NUM_SPR    = 2,
   parameter int         SCALE_SH   = 0,
   parameter logic [3:0] TRANSP_IDX = 4'h0,
   parameter logic [3:0] BG_R       = 4'h0,
   parameter logic [3:0] BG_G       = 4'h0,
   parameter logic [3:0] BG_B       = 4'h0,
   parameter int         ADDR_W     = $clog2(SPR_W*SPR_H)
) (
   input  logic                      vga_clk,
   input  logic                      reset_n,
   input  logic [9:0]                DrawX,
   input  logic [9:0]                DrawY,
   input  logic                      blank,
   input  logic [NUM_SPR*10-1:0]     pos_x,
   input  logic [NUM_SPR*10-1:0]     pos_y,
   input  logic [NUM_SPR-1:0]        spr_en,
   input  logic [NUM_SPR-1:0]        spr_flip,
   jet_sprite_renderer_if.master     mem,
   output logic [3:0]                red,
   output logic [3:0]                green,
   output logic [3:0]                blue
);

   logic [1:0] r_rst_sync;
   logic       w_rst_n;

   // Reset asserts asynchronously but leaves the pipeline on a clock edge.
   always_ff @(posedge vga_clk or negedge reset_n) begin
      if (!reset_n) r_rst_sync <= '0;
      else          r_rst_sync <= {r_rst_sync[0], 1'b1};
   end
   assign w_rst_n = r_rst_sync[1];

   logic                  w_frame_start;
   logic [NUM_SPR*10-1:0] r_act_x, r_act_y, w_cur_x, w_cur_y;
   logic [NUM_SPR-1:0]    r_act_en, w_cur_en;

   assign w_frame_start = (DrawX == '0) && (DrawY == '0);

   always_ff @(posedge vga_clk or negedge w_rst_n) begin
      if (!w_rst_n) begin
         r_act_x  <= '0;
         r_act_y  <= '0;
         r_act_en <= '0;
      end else if (w_frame_start) begin
         r_act_x  <= pos_x;
         r_act_y  <= pos_y;
         r_act_en <= spr_en;
      end
   end

   // The (0,0) pixel sees the values being captured on that same edge.
   assign w_cur_x  = w_frame_start ? pos_x  : r_act_x;
   assign w_cur_y  = w_frame_start ? pos_y  : r_act_y;
   assign w_cur_en = w_frame_start ? spr_en : r_act_en;

`ifdef JET_SPRITE_FLIP_EN
   logic [NUM_SPR-1:0] r_act_flip, w_cur_flip;

   always_ff @(posedge vga_clk or negedge w_rst_n) begin
      if (!w_rst_n)           r_act_flip <= '0;
      else if (w_frame_start) r_act_flip <= spr_flip;
   end
   assign w_cur_flip = w_frame_start ? spr_flip : r_act_flip;
`else
   logic w_unused_flip;
   assign w_unused_flip = ^spr_flip;
`endif

   logic [NUM_SPR-1:0]        w_hit;
   logic [NUM_SPR*ADDR_W-1:0] w_addr;
   logic [10:0]               w_px, w_py;

   assign w_px = {1'b0, DrawX};
   assign w_py = {1'b0, DrawY};

   genvar g;
   for (g = 0; g < NUM_SPR; g++) begin : g_spr
      logic [10:0] w_x, w_y, w_dx, w_dy, w_u, w_v;

      assign w_x  = {1'b0, w_cur_x[10*g +: 10]};
      assign w_y  = {1'b0, w_cur_y[10*g +: 10]};
      assign w_dx = w_px - w_x;
      assign w_dy = w_py - w_y;
      assign w_v  = w_dy >> SCALE_SH;
`ifdef JET_SPRITE_FLIP_EN
      assign w_u  = w_cur_flip[g] ? (11'(SPR_W - 1) - (w_dx >> SCALE_SH)) : (w_dx >> SCALE_SH);
`else
      assign w_u  = w_dx >> SCALE_SH;
`endif

      // Visible-area bound clips sprites hanging past 639/479.
      assign w_hit[g] = w_cur_en[g]
                        && (w_px >= w_x) && (w_px < w_x + 11'(SPR_W << SCALE_SH))
                        && (w_py >= w_y) && (w_py < w_y + 11'(SPR_H << SCALE_SH))
                        && (DrawX < 10'd640) && (DrawY < 10'd480);

      assign w_addr[ADDR_W*g +: ADDR_W] =
         w_hit[g] ? ADDR_W'(32'(w_v) * 32'(SPR_W) + 32'(w_u)) : '0;
   end

   logic [NUM_SPR*ADDR_W-1:0] r_rom_addr;
   logic [NUM_SPR-1:0]        r_hit1;
   logic                      r_blank1;

   always_ff @(posedge vga_clk or negedge w_rst_n) begin
      if (!w_rst_n) begin
         r_rom_addr <= '0;
         r_hit1     <= '0;
         r_blank1   <= 1'b0;
      end else begin
         r_rom_addr <= w_addr;
         r_hit1     <= w_hit;
         r_blank1   <= blank;
      end
   end
   assign mem.rom_addr = r_rom_addr;

   logic [3:0] w_sel_idx;
   logic       w_sel_bg;

   always_comb begin
      w_sel_idx = TRANSP_IDX;
      w_sel_bg  = 1'b1;
      for (int unsigned i = 0; i < NUM_SPR; i++) begin
         if (w_sel_bg && r_hit1[i] && (mem.rom_q[4*i +: 4] != TRANSP_IDX)) begin
            w_sel_idx = mem.rom_q[4*i +: 4];
            w_sel_bg  = 1'b0;
         end
      end
   end

   logic [3:0] r_pal_index;
   logic       r_bg2, r_blank2;

   always_ff @(posedge vga_clk or negedge w_rst_n) begin
      if (!w_rst_n) begin
         r_pal_index <= TRANSP_IDX;
         r_bg2       <= 1'b0;
         r_blank2    <= 1'b0;
      end else begin
         r_pal_index <= w_sel_idx;
         r_bg2       <= w_sel_bg;
         r_blank2    <= r_blank1;
      end
   end
   assign mem.pal_index = r_pal_index;

   always_ff @(posedge vga_clk or negedge w_rst_n) begin
      if (!w_rst_n) begin
         red   <= '0;
         green <= '0;
         blue  <= '0;
      end else if (!r_blank2) begin
         red   <= '0;
         green <= '0;
         blue  <= '0;
      end else if (r_bg2) begin
         red   <= BG_R;
         green <= BG_G;
         blue  <= BG_B;
      end else begin
         red   <= mem.pal_red;
         green <= mem.pal_green;
         blue  <= mem.pal_blue;
      end
   end

endmodule

// File: tb/tb_jet_sprite_renderer.sv
// Scoreboard bench for jet_sprite_renderer: randomized pixels against a behavioural sprite model.
module tb_jet_sprite_renderer;
   localparam int         W   = 80;
   localparam int         H   = 80;
   localparam int         NS  = 2;
   localparam int         SH  = 1;
   localparam int         AW  = 13;
   localparam logic [3:0] T   = 4'h0;
   localparam logic [3:0] BGR = 4'h2;
   localparam logic [3:0] BGG = 4'h9;
   localparam logic [3:0] BGB = 4'hc;

   logic             clk = 1'b0;
   logic             rst_n;
   logic [9:0]       dx, dy;
   logic             blank;
   logic [NS*10-1:0] px, py;
   logic [NS-1:0]    en, flip;
   logic [3:0]       r, g, b;

   always #5 clk = ~clk;

   jet_sprite_renderer_if #(.NUM_SPR(NS), .ADDR_W(AW)) mem_if ();

   jet_sprite_renderer #(
      .SPR_W(W), .SPR_H(H), .NUM_SPR(NS), .SCALE_SH(SH), .TRANSP_IDX(T),
      .BG_R(BGR), .BG_G(BGG), .BG_B(BGB), .ADDR_W(AW)
   ) dut (
      .vga_clk(clk), .reset_n(rst_n), .DrawX(dx), .DrawY(dy), .blank(blank),
      .pos_x(px), .pos_y(py), .spr_en(en), .spr_flip(flip), .mem(mem_if.master),
      .red(r), .green(g), .blue(b)
   );

   logic [3:0] rom [NS][1<<AW];
   logic [3:0] pr [16], pg [16], pb [16];

   always_comb begin
      mem_if.rom_q = '0;
      for (int s = 0; s < NS; s++)
         mem_if.rom_q[4*s +: 4] = rom[s][mem_if.rom_addr[AW*s +: AW]];
   end
   assign mem_if.pal_red   = pr[mem_if.pal_index];
   assign mem_if.pal_green = pg[mem_if.pal_index];
   assign mem_if.pal_blue  = pb[mem_if.pal_index];

   typedef struct { int unsigned due; logic [31:0] val; } exp_t;
   exp_t q_addr[$], q_pal[$], q_rgb[$];
   exp_t mon_e;
   int unsigned cyc = 0, n_cmp = 0, n_bad = 0;

   // Model's view of the frame-latched sprite state
   int ax[NS], ay[NS];
   bit aen[NS], aflip[NS];

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
      end
   endtask

   always @(posedge clk) begin
      cyc++;
      #1;
      while (q_addr.size() > 0 && q_addr[0].due <= cyc) begin
         mon_e = q_addr.pop_front();
         check("rom_addr", 32'(mem_if.rom_addr), mon_e.val);
      end
      while (q_pal.size() > 0 && q_pal[0].due <= cyc) begin
         mon_e = q_pal.pop_front();
         check("pal_index", 32'(mem_if.pal_index), mon_e.val);
      end
      while (q_rgb.size() > 0 && q_rgb[0].due <= cyc) begin
         mon_e = q_rgb.pop_front();
         check("rgb", 32'({r, g, b}), mon_e.val);
      end
   end

   task automatic drive(input int X, input int Y, input bit bl);
      logic [NS*AW-1:0] ea;
      logic [3:0]       idx;
      logic [11:0]      rgb;
      bit               found;
      int               sc, u, v, a;
      @(negedge clk);
      dx = 10'(X);
      dy = 10'(Y);
      blank = bl;
      if (X == 0 && Y == 0) begin
         for (int s = 0; s < NS; s++) begin
            ax[s] = int'(px[10*s +: 10]);
            ay[s] = int'(py[10*s +: 10]);
            aen[s] = en[s];
            aflip[s] = flip[s];
         end
      end
      sc = 1 << SH;
      ea = '0;
      found = 1'b0;
      idx = T;
      for (int s = 0; s < NS; s++) begin
         if (aen[s] && X >= ax[s] && X < ax[s] + W*sc && Y >= ay[s] && Y < ay[s] + H*sc
             && X < 640 && Y < 480) begin
            u = (X - ax[s]) / sc;
            v = (Y - ay[s]) / sc;
`ifdef JET_SPRITE_FLIP_EN
            if (aflip[s]) u = W - 1 - u;
`endif
            a = v*W + u;
            ea[AW*s +: AW] = AW'(a);
            if (!found && rom[s][a] != T) begin
               found = 1'b1;
               idx = rom[s][a];
            end
         end
      end
      if (!bl)        rgb = '0;
      else if (!found) rgb = {BGR, BGG, BGB};
      else            rgb = {pr[idx], pg[idx], pb[idx]};
      q_addr.push_back('{cyc + 1, 32'(ea)});
      q_pal.push_back('{cyc + 2, 32'(idx)});
      q_rgb.push_back('{cyc + 3, 32'(rgb)});
   endtask

   task automatic flush();
      repeat (3) drive(700, 500, 1'b0);
   endtask

   task automatic set_spr(input int s, input int x, input int y, input bit e, input bit f);
      px[10*s +: 10] = 10'(x);
      py[10*s +: 10] = 10'(y);
      en[s] = e;
      flip[s] = f;
   endtask

   initial begin
      int X, Y, s;
      bit bl;
      for (int k = 0; k < NS; k++)
         for (int i = 0; i < (1 << AW); i++)
            rom[k][i] = ($urandom_range(0, 3) == 0) ? T : 4'($urandom_range(1, 15));
      for (int i = 0; i < 16; i++) begin
         pr[i] = 4'($urandom);
         pg[i] = 4'($urandom);
         pb[i] = 4'($urandom);
      end
      pr[5] = 4'hf; pg[5] = 4'h0; pb[5] = 4'h0;
      for (int k = 0; k < NS; k++) begin
         ax[k] = 0; ay[k] = 0; aen[k] = 1'b0; aflip[k] = 1'b0;
      end

      rst_n = 1'b0; blank = 1'b1; dx = 10'd100; dy = 10'd50;
      px = '0; py = '0; en = '1; flip = '0;
      repeat (3) @(negedge clk);
      check("reset_rgb", 32'({r, g, b}), 32'h0);
      check("reset_rom_addr", 32'(mem_if.rom_addr), 32'h0);
      check("reset_pal_index", 32'(mem_if.pal_index), 32'(T));
      rst_n = 1'b1;
      en = '0;
      repeat (4) @(negedge clk);

      // Single sprite at (100,50)
      rom[0][0] = 4'h5;
      set_spr(0, 100, 50, 1'b1, 1'b0);
      set_spr(1, 0, 0, 1'b0, 1'b0);
      drive(0, 0, 1'b1);
      drive(100, 50, 1'b1);
      drive(99, 50, 1'b1);
      drive(101, 51, 1'b1);
      drive(100, 50, 1'b0);
      drive(259, 209, 1'b1);
      drive(260, 50, 1'b1);

      // Transparency and priority on overlap
      flush();
      rom[0][0] = T;    rom[1][2025] = 4'h3;
      rom[0][1] = 4'h7; rom[1][2026] = 4'h3;
      set_spr(0, 200, 200, 1'b1, 1'b0);
      set_spr(1, 150, 150, 1'b1, 1'b0);
      drive(0, 0, 1'b1);
      drive(200, 200, 1'b1);
      drive(202, 200, 1'b1);

      // Scale-2 addressing with sprite at origin
      flush();
      rom[0][0] = 4'h5;
      set_spr(0, 0, 0, 1'b1, 1'b0);
      set_spr(1, 0, 0, 1'b0, 1'b0);
      drive(0, 0, 1'b1);
      drive(1, 1, 1'b1);
      drive(2, 0, 1'b1);
      drive(159, 159, 1'b1);
      drive(160, 0, 1'b1);

      // Mid-frame position change waits for next frame start
      set_spr(0, 300, 100, 1'b1, 1'b0);
      drive(0, 0, 1'b1);
      drive(310, 240, 1'b1);
      px[9:0] = 10'd500;
      drive(310, 240, 1'b1);
      drive(510, 240, 1'b1);
      drive(0, 0, 1'b1);
      drive(310, 240, 1'b1);
      drive(510, 240, 1'b1);

      // Randomized frames
      for (int f = 0; f < 8; f++) begin
         for (int k = 0; k < NS; k++)
            set_spr(k, $urandom_range(0, 639), $urandom_range(0, 479),
                    $urandom_range(0, 3) != 0, 1'($urandom));
         drive(0, 0, 1'($urandom));
         for (int p = 0; p < 300; p++) begin
            if ($urandom_range(0, 3) == 0) begin
               X = $urandom_range(0, 799);
               Y = $urandom_range(0, 524);
            end else begin
               s = $urandom_range(0, NS - 1);
               X = ax[s] + $urandom_range(0, W*2 + 10) - 5;
               Y = ay[s] + $urandom_range(0, H*2 + 10) - 5;
               if (X < 0) X = 0;
               if (X > 799) X = 799;
               if (Y < 0) Y = 0;
               if (Y > 524) Y = 524;
            end
            bl = (X < 640) && (Y < 480) && ($urandom_range(0, 7) != 0);
            drive(X, Y, bl);
         end
      end

      repeat (6) @(posedge clk);
      #2;
      if (q_addr.size() + q_pal.size() + q_rgb.size() != 0)
         check("drain", 32'(q_addr.size() + q_pal.size() + q_rgb.size()), 32'h0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule

// File: doc/jet_sprite_renderer.md
# jet_sprite_renderer

Multi-sprite pixel pipeline for the jet fighter VGA display. Each of NUM_SPR sprites has its own screen position, enable and optional integer scale; the block turns the current DrawX/DrawY into per-sprite ROM addresses, applies transparency and fixed priority, and drives the palette-resolved RGB pixel. It sits between the VGA controller and the colour mapper and replaces the full-screen single-sprite stretch renderer.

## Interface
- SPR_W, 80: sprite width in texels
- SPR_H, 80: sprite height in texels
- NUM_SPR, 2: number of sprite channels (1..4)
- SCALE_SH, 0: texel-to-pixel scale is 2^SCALE_SH (0..2)
- TRANSP_IDX, 0: palette index treated as transparent
- BG_R / BG_G / BG_B, 4'h0: background colour
- ADDR_W, $clog2(SPR_W*SPR_H): ROM address width

- vga_clk  in  1  pixel clock; all logic on posedge
- reset_n  in  1  asynchronous, active-low reset
- DrawX, DrawY  in  10 each  current pixel coordinate
- blank  in  1  1 = visible region, 0 = blanking
- pos_x, pos_y  in  NUM_SPR*10 each  sprite top-left, packed, sprite i at [10i+9:10i]
- spr_en  in  NUM_SPR  per-sprite enable
- spr_flip  in  NUM_SPR  per-sprite horizontal mirror (used only with macro)
- rom_addr  out  NUM_SPR*ADDR_W  per-sprite ROM address
- rom_q  in  NUM_SPR*4  per-sprite ROM data, valid one cycle after rom_addr
- pal_index  out  4  selected palette index
- pal_red, pal_green, pal_blue  in  4 each  combinational palette result for pal_index
- red, green, blue  out  4 each  registered pixel colour

## Operation
- Shadow registers: pos_x/pos_y/spr_en/spr_flip are captured into active registers only on the cycle where DrawX==0 && DrawY==0. Changes at any other time have no effect until the next frame start. Reset clears active registers (all sprites disabled, positions 0).
- Hit test (S1), 11-bit unsigned arithmetic, no wrap: dx = DrawX - x, dy = DrawY - y; hit_i = en_i && DrawX >= x && DrawX < x + (SPR_W<<SCALE_SH) && same for Y. Sprites extending past 639/479 are clipped.
- Address: u = dx>>SCALE_SH, v = dy>>SCALE_SH; rom_addr_i = v*SPR_W + u, registered. Non-hit channels drive address 0.
- S2: rom_q returns; opaque_i = hit_i (delayed) && rom_q_i != TRANSP_IDX.
- Priority: lowest-index opaque sprite wins. pal_index is registered at end of S2; if no opaque sprite, an internal bg flag is set and pal_index = TRANSP_IDX.
- Output (S3): if delayed blank==0 → red/green/blue = 0; else if bg flag → BG_*; else pal_red/green/blue.
- blank, bg and hit flags are delayed alongside data so every output belongs to one DrawX/DrawY.

## Timing
- Latency: pixel presented at edge t appears on red/green/blue after edge t+3; rom_addr valid after edge t+1; pal_index after edge t+2.
- Throughput: one pixel per cycle, no stalls.
- Reset (async assert, sync release inside pipeline): red/green/blue = 0, rom_addr = 0, pal_index = TRANSP_IDX, all pipeline valid/blank flags 0. Reset mid-line drops in-flight pixels; first output after release is 0 until three blanked-aligned stages refill.
- Frame-start capture and a pixel at (0,0) in the same cycle: the (0,0) pixel uses the newly captured values.

## Configuration
- JET_SPRITE_FLIP_EN defined: when active spr_flip_i=1, u = (SPR_W-1) - (dx>>SCALE_SH); flip captured with the shadow registers.
- Undefined: spr_flip ignored, no mirror logic synthesised; u = dx>>SCALE_SH.

## Test plan
- Reset: hold reset_n=0 with blank=1 → red/green/blue=0, rom_addr=0, pal_index=TRANSP_IDX.
- Single sprite: sprite0 at (100,50), enabled from frame start, rom_q0=4'h5 for addr 0, palette 5→(F,0,0) → pixel (100,50) gives rom_addr0=0 at t+1, RGB F/0/0 at t+3; pixel (99,50) → BG.
- Transparency/priority: sprites 0 and 1 overlap at (200,200); rom_q0=TRANSP_IDX, rom_q1=3 → pal_index=3; then rom_q0=7 → pal_index=7.
- Scale: SCALE_SH=1, sprite at (0,0): pixels (0,0),(1,1) → addr 0; (2,0) → addr 1; (159,159) → addr 6399; (160,0) → no hit.
- Shadow update: change pos_x0 mid-frame at line 240 → remainder of frame uses old position, new position after next (0,0).
- Flip (macro on): sprite0 at (0,0), spr_flip0=1 → pixel (0,0) addr 79, (79,0) addr 0; blank=0 anywhere → RGB 0.
